// File: rtl/cache_arbiter.sv
// cache_arbiter: two-requester arbiter/sequencer in front of a 4-entry associative cache.
// Ports:
//   i_clk, i_clr                 clock, asynchronous active-high reset
//   i_a_* / o_a_*                requester A (instruction fetch): req, rw, addr, wdata, ack, rdata
//   i_b_* / o_b_*                requester B (accumulator data port): same set as A
//   o_c_clr, o_c_enab, o_c_rw,   cache control: active-low clear, enable, rw,
//   o_c_addr, o_c_wdata          latched address and write data
//   i_c_rdata, i_c_state, i_c_hit  cache data_out, state register, hit flag
//   o_owner, o_busy, o_last_hit, o_timeout_err  status
// Option: define CACHE_ARB_FIXED_PRIO_EN for fixed priority (A wins ties); default is round-robin.
module cache_arbiter #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 8,
    parameter int TIMEOUT = 31
) (
    input  logic               i_clk,
    input  logic               i_clr,
    input  logic               i_a_req,
    input  logic               i_a_rw,
    input  logic [A_WIDTH-1:0] i_a_addr,
    input  logic [D_WIDTH-1:0] i_a_wdata,
    output logic               o_a_ack,
    output logic [D_WIDTH-1:0] o_a_rdata,
    input  logic               i_b_req,
    input  logic               i_b_rw,
    input  logic [A_WIDTH-1:0] i_b_addr,
    input  logic [D_WIDTH-1:0] i_b_wdata,
    output logic               o_b_ack,
    output logic [D_WIDTH-1:0] o_b_rdata,
    output logic               o_c_clr,
    output logic               o_c_enab,
    output logic               o_c_rw,
    output logic [A_WIDTH-1:0] o_c_addr,
    output logic [D_WIDTH-1:0] o_c_wdata,
    input  logic [D_WIDTH-1:0] i_c_rdata,
    input  logic [3:0]         i_c_state,
    input  logic               i_c_hit,
    output logic               o_owner,
    output logic               o_busy,
    output logic               o_last_hit,
    output logic               o_timeout_err
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE} state_t;

    state_t     r_state;
    logic [4:0] r_cnt;
    logic       w_win;
    logic       w_to;

`ifdef CACHE_ARB_FIXED_PRIO_EN
    assign w_win = ~i_a_req;
`else
    // On a tie the requester that did not own the last grant wins.
    assign w_win = (i_a_req & i_b_req) ? ~o_owner : ~i_a_req;
`endif

    // Last BUSY cycle before abort; the counter reaches TIMEOUT on the edge that leaves BUSY.
    assign w_to    = (r_cnt == 5'(TIMEOUT - 1));
    assign o_c_clr = ~i_clr;
    // Enable drops in the cycle the cache reports state 0 so it does not start again.
    assign o_c_enab = (r_state == S_ISSUE) |
                      ((r_state == S_BUSY) & (i_c_state != 4'd0) & ~w_to);

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_state       <= S_IDLE;
            r_cnt         <= 5'd0;
            o_a_ack       <= 1'b0;
            o_b_ack       <= 1'b0;
            o_a_rdata     <= '0;
            o_b_rdata     <= '0;
            o_owner       <= 1'b1;
            o_c_rw        <= 1'b0;
            o_c_addr      <= '0;
            o_c_wdata     <= '0;
            o_busy        <= 1'b0;
            o_last_hit    <= 1'b0;
            o_timeout_err <= 1'b0;
        end else begin
            o_a_ack <= 1'b0;
            o_b_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_a_req | i_b_req) begin
                        o_owner   <= w_win;
                        o_c_rw    <= w_win ? i_b_rw : i_a_rw;
                        o_c_addr  <= w_win ? i_b_addr : i_a_addr;
                        o_c_wdata <= w_win ? i_b_wdata : i_a_wdata;
                        o_busy    <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= 5'd0;
                    r_state <= S_BUSY;
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (i_c_state == 4'd0) begin
                        if (o_owner) o_b_rdata <= i_c_rdata;
                        else o_a_rdata <= i_c_rdata;
                        o_last_hit <= i_c_hit;
                        o_a_ack    <= ~o_owner;
                        o_b_ack    <= o_owner;
                        r_state    <= S_DONE;
                    end else if (w_to) begin
                        if (o_owner) o_b_rdata <= '0;
                        else o_a_rdata <= '0;
                        o_timeout_err <= 1'b1;
                        o_a_ack       <= ~o_owner;
                        o_b_ack       <= o_owner;
                        r_state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: randomized self-checking bench for cache_arbiter with a cache model and reference model.
module tb_cache_arbiter;
    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       a_req = 1'b0, a_rw = 1'b0, b_req = 1'b0, b_rw = 1'b0;
    logic [7:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
    logic       a_ack, b_ack, c_clr, c_enab, c_rw, c_hit, owner, busy, last_hit, timeout_err;
    logic [7:0] a_rdata, b_rdata, c_addr, c_wdata;
    logic [7:0] c_rdata = '0;
    logic [3:0] c_state;

    // cache environment model
    logic [3:0] m_state = '0, m_n = '0;
    logic       m_hit = 1'b0;
    logic [7:0] m_tag[4] = '{default: 8'h00};
    logic [7:0] m_dat[4] = '{default: 8'h00};
    logic       m_vld[4] = '{default: 1'b0};
    logic [7:0] m_bak[256] = '{default: 8'h00};
    logic [1:0] m_rep = '0;
    int         m_k;
    bit         stuck = 1'b0;

    // reference model
    logic [7:0] ref_data[256] = '{default: 8'h00};
    bit         seen[256];
    bit         owner_m = 1'b1, err_m = 1'b0, to_mode = 1'b0;
    logic [7:0] pool[4] = '{8'h10, 8'h42, 8'h07, 8'hC3};
    int         n_vec = 0, n_err = 0;

    assign c_state = stuck ? 4'd5 : m_state;
    assign c_hit   = m_hit;

    cache_arbiter dut (
        .i_clk(clk), .i_clr(clr),
        .i_a_req(a_req), .i_a_rw(a_rw), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
        .o_a_ack(a_ack), .o_a_rdata(a_rdata),
        .i_b_req(b_req), .i_b_rw(b_rw), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
        .o_b_ack(b_ack), .o_b_rdata(b_rdata),
        .o_c_clr(c_clr), .o_c_enab(c_enab), .o_c_rw(c_rw), .o_c_addr(c_addr),
        .o_c_wdata(c_wdata), .i_c_rdata(c_rdata), .i_c_state(c_state), .i_c_hit(c_hit),
        .o_owner(owner), .o_busy(busy), .o_last_hit(last_hit), .o_timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        m_k = -1;
        for (int i = 3; i >= 0; i--) if (m_vld[i] && m_tag[i] == c_addr) m_k = i;
    end

    // hit: 2 nonzero state cycles, miss: 12; write-through, FIFO replacement
    always @(posedge clk) begin
        if (!c_clr) begin
            m_state <= '0;
            m_rep   <= '0;
            for (int i = 0; i < 4; i++) m_vld[i] <= 1'b0;
        end else if (m_state != 4'd0) begin
            m_state <= (m_state == m_n) ? 4'd0 : m_state + 4'd1;
        end else if (c_enab) begin
            m_state <= 4'd1;
            m_hit   <= (m_k >= 0);
            m_n     <= (m_k >= 0) ? 4'd2 : 4'd12;
            if (m_k >= 0) begin
                if (c_rw) m_dat[m_k[1:0]] <= c_wdata;
                else c_rdata <= m_dat[m_k[1:0]];
            end else begin
                m_tag[m_rep] <= c_addr;
                m_vld[m_rep] <= 1'b1;
                m_dat[m_rep] <= c_rw ? c_wdata : m_bak[c_addr];
                if (!c_rw) c_rdata <= m_bak[c_addr];
                m_rep <= m_rep + 2'd1;
            end
            if (c_rw) m_bak[c_addr] <= c_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Raise the given requests from IDLE and check nacks completions against the reference model.
    task automatic do_req(input bit ra, input bit rb, input bit hold, input int nacks,
                          input bit arw, input bit brw, input logic [7:0] aad, input logic [7:0] bad,
                          input logic [7:0] awd, input logic [7:0] bwd);
        logic [1:0] rem;
        logic [7:0] ad, wd;
        bit         w, rw, first, hit, en_prev, got;
        int         lat, exp_lat;
        @(negedge clk);
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        a_req = ra; b_req = rb; a_rw = arw; b_rw = brw;
        a_addr = aad; b_addr = bad; a_wdata = awd; b_wdata = bwd;
        rem = {rb, ra};
        first = 1'b1;
        for (int k = 0; k < nacks; k++) begin
`ifdef CACHE_ARB_FIXED_PRIO_EN
            w = !rem[0];
`else
            w = (rem == 2'b11) ? !owner_m : rem[1];
`endif
            rw = w ? brw : arw;
            ad = w ? bad : aad;
            wd = w ? bwd : awd;
            hit = seen[ad];
            exp_lat = (to_mode ? 32 : (hit ? 4 : 14)) + (first ? 1 : 2);
            lat = 0;
            got = 1'b0;
            en_prev = c_enab;
            while (!got && lat < 80) begin
                @(posedge clk);
                #1;
                lat++;
                got = a_ack | b_ack;
                if (!got) en_prev = c_enab;
            end
            check("ack_seen", 32'(got), 1);
            if (!got) break;
            check("latency", lat, exp_lat);
            check("ack_owner", 32'(b_ack), 32'(w));
            check("one_ack", 32'(a_ack & b_ack), 0);
            check("enab_off", 32'(en_prev), 0);
            check("c_addr", 32'(c_addr), 32'(ad));
            check("c_rw", 32'(c_rw), 32'(rw));
            check("owner", 32'(owner), 32'(w));
            check("timeout_err", 32'(timeout_err), 32'(err_m));
            if (!rw) check("rdata", 32'(w ? b_rdata : a_rdata), to_mode ? 0 : 32'(ref_data[ad]));
            if (!to_mode) begin
                check("last_hit", 32'(last_hit), 32'(hit));
                seen[ad] = 1'b1;
                if (rw) ref_data[ad] = wd;
            end
            owner_m = w;
            first = 1'b0;
            if (!hold) begin
                rem[w] = 1'b0;
                if (w) b_req = 1'b0;
                else a_req = 1'b0;
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no summary by time limit");
        $fatal(1);
    end

    initial begin
        #1 clr = 1'b1;
        #1;
        check("rst_a_ack", 32'(a_ack), 0);
        check("rst_b_ack", 32'(b_ack), 0);
        check("rst_a_rdata", 32'(a_rdata), 0);
        check("rst_b_rdata", 32'(b_rdata), 0);
        check("rst_owner", 32'(owner), 1);
        check("rst_c_rw", 32'(c_rw), 0);
        check("rst_c_addr", 32'(c_addr), 0);
        check("rst_c_wdata", 32'(c_wdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_last_hit", 32'(last_hit), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_c_enab", 32'(c_enab), 0);
        check("rst_c_clr", 32'(c_clr), 0);
        @(negedge clk);
        @(negedge clk) clr = 1'b0;

        do_req(1, 0, 0, 1, 1, 0, 8'h10, 8'h00, 8'h5A, 8'h00);
        do_req(1, 0, 0, 1, 0, 0, 8'h10, 8'h00, 8'h00, 8'h00);
        do_req(0, 1, 0, 1, 0, 1, 8'h00, 8'h42, 8'h00, 8'h33);
        do_req(0, 1, 0, 1, 0, 0, 8'h00, 8'h42, 8'h00, 8'h00);
        do_req(1, 1, 0, 2, 0, 0, 8'h10, 8'h42, 8'h00, 8'h00);
        do_req(1, 1, 0, 2, 0, 0, 8'h10, 8'h42, 8'h00, 8'h00);
        do_req(1, 1, 1, 4, 0, 0, 8'h07, 8'hC3, 8'h00, 8'h00);

        for (int t = 0; t < 40; t++) begin
            int r;
            r = int'($urandom_range(1, 3));
            do_req(r[0], r[1], 0, (r == 3) ? 2 : 1, 1'($urandom), 1'($urandom),
                   pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)],
                   8'($urandom), 8'($urandom));
        end

        stuck = 1'b1;
        to_mode = 1'b1;
        err_m = 1'b1;
        do_req(1, 0, 0, 1, 0, 0, 8'h10, 8'h00, 8'h00, 8'h00);
        stuck = 1'b0;
        to_mode = 1'b0;
        do_req(0, 1, 0, 1, 0, 0, 8'h00, 8'h42, 8'h00, 8'h00);

        // clear the cache so the next read misses, then abort it mid-BUSY
        @(negedge clk) clr = 1'b1;
        @(negedge clk);
        @(negedge clk) clr = 1'b0;
        foreach (seen[i]) seen[i] = 1'b0;
        owner_m = 1'b1;
        err_m = 1'b0;
        @(negedge clk);
        a_req = 1'b1; a_rw = 1'b0; a_addr = 8'h10;
        repeat (6) @(posedge clk);
        #3 clr = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_c_enab", 32'(c_enab), 0);
        check("abort_c_clr", 32'(c_clr), 0);
        check("abort_a_rdata", 32'(a_rdata), 0);
        check("abort_owner", 32'(owner), 1);
        check("abort_c_addr", 32'(c_addr), 0);
        check("abort_timeout_err", 32'(timeout_err), 0);
        a_req = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1 check("abort_no_ack", 32'(a_ack | b_ack), 0);
        end
        @(negedge clk) clr = 1'b0;
        do_req(1, 0, 0, 1, 0, 0, 8'h10, 8'h00, 8'h00, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
